// File: rtl/source_arbiter.sv
// rtl/source_arbiter.sv - fixed-priority three-source arbiter with hold/release timing and a dead gap between grants
module source_arbiter #(
    parameter int HOLD_TICKS    = 50,
    parameter int RELEASE_TICKS = 10,
    parameter int GAP_CYCLES    = 2
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic [2:0] iReq,
    input  logic       iTick,
    output logic [3:0] oAddress,
    output logic       oBusy,
    output logic       oSwitch
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = $clog2(RELEASE_TICKS + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [RW-1:0] REL_MAX  = RW'(RELEASE_TICKS);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE, GAP} state_t;

    state_t          state;
    logic [1:0]      g;
    logic [HW-1:0]   hold_cnt;
    logic [RW-1:0]   rel_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            win_valid;
    logic [1:0]      win;
    logic            own_req;
    logic            higher;
    logic            hold_full;
    logic            rel_full;

    always_comb begin
        win_valid = |iReq;
        win       = 2'd2;
        if (iReq[0])
            win = 2'd0;
        else if (iReq[1])
            win = 2'd1;

        own_req = 1'b0;
        higher  = 1'b0;
        case (g)
            2'd0: own_req = iReq[0];
            2'd1: begin
                own_req = iReq[1];
                higher  = iReq[0];
            end
            2'd2: begin
                own_req = iReq[2];
                higher  = |iReq[1:0];
            end
            default: begin
                own_req = 1'b0;
                higher  = 1'b0;
            end
        endcase

        hold_full = (hold_cnt == HOLD_MAX);
        rel_full  = (rel_cnt == REL_MAX);
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state    <= IDLE;
            g        <= 2'd0;
            hold_cnt <= '0;
            rel_cnt  <= '0;
            gap_cnt  <= '0;
            oAddress <= 4'd0;
            oBusy    <= 1'b0;
            oSwitch  <= 1'b0;
        end else begin
            oSwitch <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state    <= GRANT;
                        g        <= win;
                        hold_cnt <= '0;
                        oAddress <= 4'b0001 << win;
                        oBusy    <= 1'b1;
                        oSwitch  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (iTick && !hold_full)
                        hold_cnt <= hold_cnt + HW'(1);
                    if (!own_req) begin
                        state   <= RELEASE;
                        rel_cnt <= '0;
                    end else if (hold_full && higher) begin
                        state    <= GAP;
                        gap_cnt  <= '0;
                        oAddress <= 4'd0;
                    end
                end
                RELEASE: begin
                    // A re-asserted request always wins over any reason to let go.
                    if (own_req) begin
                        state <= GRANT;
                    end else if (rel_full || (higher && hold_full)) begin
                        state    <= GAP;
                        gap_cnt  <= '0;
                        oAddress <= 4'd0;
                    end else if (iTick) begin
                        rel_cnt <= rel_cnt + RW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (win_valid) begin
                            state    <= GRANT;
                            g        <= win;
                            hold_cnt <= '0;
                            oAddress <= 4'b0001 << win;
                            oSwitch  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            oBusy <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    oAddress <= 4'd0;
                    oBusy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_source_arbiter.sv
// tb/tb_source_arbiter.sv - directed and randomized checks of source_arbiter against a behavioural model
module tb_source_arbiter;

    localparam int H = 4;
    localparam int R = 2;
    localparam int G = 2;

    logic       iClk = 1'b0;
    logic       iReset_n;
    logic [2:0] iReq;
    logic       iTick;
    logic [3:0] oAddress;
    logic       oBusy;
    logic       oSwitch;

    int compared   = 0;
    int mismatched = 0;

    // Model: owner (-1 none), whether owner has dropped its request, tick counts, remaining gap cycles.
    int m_owner   = -1;
    bit m_dropped = 1'b0;
    int m_held    = 0;
    int m_drop    = 0;
    int m_gap     = 0;
    bit m_sw      = 1'b0;

    always #5 iClk = ~iClk;

    source_arbiter #(
        .HOLD_TICKS   (H),
        .RELEASE_TICKS(R),
        .GAP_CYCLES   (G)
    ) dut (
        .iClk    (iClk),
        .iReset_n(iReset_n),
        .iReq    (iReq),
        .iTick   (iTick),
        .oAddress(oAddress),
        .oBusy   (oBusy),
        .oSwitch (oSwitch)
    );

    function automatic int lowest(input logic [2:0] r);
        for (int i = 0; i < 3; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge iClk or negedge iReset_n) begin : model
        int w;
        bit hi;
        if (!iReset_n) begin
            m_owner = -1; m_dropped = 1'b0; m_held = 0; m_drop = 0; m_gap = 0; m_sw = 1'b0;
        end else begin
            m_sw = 1'b0;
            w    = lowest(iReq);
            if (m_gap > 0) begin
                if (m_gap == 1) begin
                    m_gap = 0;
                    if (w >= 0) begin
                        m_owner = w; m_held = 0; m_dropped = 1'b0; m_sw = 1'b1;
                    end else begin
                        m_owner = -1;
                    end
                end else begin
                    m_gap--;
                end
            end else if (m_owner < 0) begin
                if (w >= 0) begin
                    m_owner = w; m_held = 0; m_dropped = 1'b0; m_sw = 1'b1;
                end
            end else begin
                hi = (w >= 0) && (w < m_owner);
                if (!m_dropped) begin
                    if (!iReq[m_owner]) begin
                        m_dropped = 1'b1; m_drop = 0;
                    end else if (m_held == H && hi) begin
                        m_gap = G;
                    end
                    if (iTick && m_held < H) m_held++;
                end else begin
                    if (iReq[m_owner])
                        m_dropped = 1'b0;
                    else if (m_drop == R || (hi && m_held == H))
                        m_gap = G;
                    else if (iTick && m_drop < R)
                        m_drop++;
                end
            end
        end
    end

    always @(negedge iClk) begin : compare
        logic [3:0] ea;
        ea = 4'd0;
        if (m_owner >= 0 && m_gap == 0) ea[m_owner] = 1'b1;
        chk("model_addr", oAddress, ea);
        chk("model_busy", {3'd0, oBusy}, {3'd0, (m_owner >= 0) || (m_gap > 0)});
        chk("model_switch", {3'd0, oSwitch}, {3'd0, m_sw});
    end

    task automatic drive(input logic [2:0] r, input logic t);
        iReq  = r;
        iTick = t;
        @(posedge iClk);
        #2;
    endtask

    task automatic do_reset();
        iReset_n = 1'b0;
        iReq     = 3'd0;
        iTick    = 1'b0;
        #1;
        chk("reset_addr", oAddress, 4'd0);
        chk("reset_busy", {3'd0, oBusy}, 4'd0);
        chk("reset_switch", {3'd0, oSwitch}, 4'd0);
        @(posedge iClk);
        #2;
        iReset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] r;
        logic       t;

        do_reset();
        drive(3'b110, 1'b0);
        chk("first_grant_addr", oAddress, 4'd2);
        chk("first_grant_switch", {3'd0, oSwitch}, 4'd1);
        chk("first_grant_busy", {3'd0, oBusy}, 4'd1);
        drive(3'b110, 1'b0);
        chk("switch_one_cycle", {3'd0, oSwitch}, 4'd0);

        do_reset();
        drive(3'b100, 1'b0);
        drive(3'b100, 1'b1);
        drive(3'b101, 1'b1);
        drive(3'b101, 1'b1);
        drive(3'b101, 1'b1);
        chk("preempt_hold_addr", oAddress, 4'd4);
        drive(3'b101, 1'b0);
        chk("preempt_gap1_addr", oAddress, 4'd0);
        chk("preempt_gap1_busy", {3'd0, oBusy}, 4'd1);
        drive(3'b101, 1'b0);
        chk("preempt_gap2_addr", oAddress, 4'd0);
        drive(3'b101, 1'b0);
        chk("preempt_new_addr", oAddress, 4'd1);
        chk("preempt_new_switch", {3'd0, oSwitch}, 4'd1);

        do_reset();
        drive(3'b001, 1'b0);
        drive(3'b000, 1'b1);
        chk("drop_addr", oAddress, 4'd1);
        drive(3'b000, 1'b1);
        chk("drop_tick_addr", oAddress, 4'd1);
        drive(3'b001, 1'b0);
        chk("regrant_addr", oAddress, 4'd1);
        chk("regrant_switch", {3'd0, oSwitch}, 4'd0);

        do_reset();
        drive(3'b010, 1'b0);
        drive(3'b000, 1'b0);
        drive(3'b000, 1'b1);
        drive(3'b000, 1'b1);
        chk("release_wait_addr", oAddress, 4'd2);
        drive(3'b000, 1'b0);
        chk("release_gap1_addr", oAddress, 4'd0);
        drive(3'b000, 1'b0);
        chk("release_gap2_busy", {3'd0, oBusy}, 4'd1);
        drive(3'b000, 1'b0);
        chk("release_idle_busy", {3'd0, oBusy}, 4'd0);
        chk("release_idle_addr", oAddress, 4'd0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(3'b111, 1'b1);
            chk("top_priority_addr", oAddress, 4'd1);
        end

        do_reset();
        drive(3'b010, 1'b0);
        drive(3'b000, 1'b0);
        drive(3'b000, 1'b1);
        drive(3'b000, 1'b1);
        drive(3'b000, 1'b0);
        chk("gap_before_reset_busy", {3'd0, oBusy}, 4'd1);
        #1 iReset_n = 1'b0;
        #1;
        chk("async_reset_addr", oAddress, 4'd0);
        chk("async_reset_busy", {3'd0, oBusy}, 4'd0);
        iReset_n = 1'b1;
        drive(3'b100, 1'b0);
        chk("after_reset_addr", oAddress, 4'd4);
        chk("after_reset_switch", {3'd0, oSwitch}, 4'd1);

        r = 3'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            t = ($urandom_range(0, 2) == 0);
            drive(r, t);
            if ($urandom_range(0, 299) == 0) begin
                #1 iReset_n = 1'b0;
                #1 iReset_n = 1'b1;
            end
        end

        @(negedge iClk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/source_arbiter.md
SOURCE_ARBITER -- requirements
Module: source_arbiter

Interface
REQ-001 Parameter HOLD_TICKS, 50, minimum iTick count a grant is held before preemption (>=1).
REQ-002 Parameter RELEASE_TICKS, 10, consecutive iTick count of dropped request before release (>=1).
REQ-003 Parameter GAP_CYCLES, 2, clock cycles oAddress is forced to 0 between grants (>=1).
REQ-004 iClk  input  1  clock; all state changes on rising edge.
REQ-005 iReset_n  input  1  reset, asynchronous, active-low.
REQ-006 iReq  input  3  request per source; bit0 = source 1 (highest priority), bit2 = source 3 (lowest).
REQ-007 iTick  input  1  single-cycle timebase enable pulse (nominal 1 ms).
REQ-008 oAddress  output  4  registered one-hot grant code for the data selector: 1, 2, 4 or 0 (none).
REQ-009 oBusy  output  1  high whenever state is not IDLE.
REQ-010 oSwitch  output  1  one-cycle pulse on the first cycle of each new non-zero oAddress.

Function
REQ-011 The block SHALL implement states IDLE, GRANT, RELEASE and GAP; the granted source index g is held in a register.
REQ-012 oAddress SHALL equal 0 in IDLE and GAP, and 1<<g in GRANT and RELEASE; it SHALL never hold any value other than 0, 1, 2 or 4.
REQ-013 Arbitration SHALL be fixed priority, lowest set bit of iReq wins.
REQ-014 IDLE: on an edge sampling iReq != 0, the block SHALL enter GRANT with g = winner, hold counter = 0, and oAddress and oSwitch updated at that same edge.
REQ-015 Hold and release counters SHALL be cleared on state entry, increment only on edges sampling iTick = 1 while in the state (not on the entry edge), and saturate at their limit.
REQ-016 GRANT: iReq[g] = 0 SHALL move to RELEASE (release counter = 0, hold counter kept).
REQ-017 GRANT: with iReq[g] = 1, hold counter = HOLD_TICKS and a higher-priority request present, the block SHALL move to GAP.
REQ-018 RELEASE: iReq[g] = 1 SHALL return to GRANT with hold counter kept and no oSwitch pulse.
REQ-019 RELEASE: release counter reaching RELEASE_TICKS, or a higher-priority request with hold counter = HOLD_TICKS, SHALL move to GAP; a simultaneous iReq[g] re-assertion takes precedence (stay granted).
REQ-020 GAP SHALL last exactly GAP_CYCLES clock cycles regardless of iTick; on its last edge the block SHALL re-arbitrate the iReq sampled on that edge: winner -> GRANT (oSwitch pulse, even if winner = previous g); none -> IDLE.
REQ-021 Lower-priority requests SHALL never preempt a grant; they are served only via GAP re-arbitration.
REQ-022 oSwitch SHALL be 0 in every cycle other than those defined in REQ-014 and REQ-020.
REQ-023 iReq and iTick are synchronous to iClk; no internal synchronisers.

Reset
REQ-024 Asserting iReset_n low SHALL immediately, without a clock edge, force IDLE, g = 0, counters = 0, oAddress = 0, oBusy = 0, oSwitch = 0.
REQ-025 Reset asserted mid-grant or mid-gap SHALL discard all pending state; after deassertion the first edge with iReq != 0 follows REQ-014.
REQ-026 Deassertion SHALL take effect at the first rising edge after iReset_n goes high.

Verification (HOLD_TICKS=4, RELEASE_TICKS=2, GAP_CYCLES=2)
REQ-027 Reset, then iReq=3'b110 -> same edge oAddress=2, oSwitch=1 for one cycle, oBusy=1.
REQ-028 Grant source 3, raise iReq bit0 after 1 tick -> oAddress stays 4 until 4th tick edge, then 0 for 2 cycles, then 1 with oSwitch pulse.
REQ-029 Grant source 1, drop iReq for 1 tick then reassert -> oAddress stays 1 throughout, no oSwitch pulse.
REQ-030 Grant source 2, drop iReq for 2 ticks, iReq=0 -> oAddress 0 for 2 cycles, then IDLE, oBusy=0.
REQ-031 iReq=3'b111 held, iTick every cycle -> oAddress stays 1 forever; bits 1 and 2 never granted.
REQ-032 iReset_n pulsed low during GAP between clock edges -> oAddress=0, oBusy=0 immediately; iReq=3'b100 after release -> oAddress=4.
